// File: rtl/apb_i2c_pkg.sv
// Shared types and constants for the APB I2C command master.
package apb_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] ADDR_TX  = 32'd0;
  localparam logic [31:0] ADDR_RX  = 32'd4;
  localparam logic [31:0] ADDR_CFG = 32'd8;
  localparam logic [31:0] ADDR_TMO = 32'd12;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // TX is write-only, RX is read-only, CFG/TMO accept both directions.
  function automatic logic cmd_legal(input logic write, input logic [31:0] addr);
    case (addr)
      ADDR_TX:            return write;
      ADDR_RX:            return !write;
      ADDR_CFG, ADDR_TMO: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/apb_i2c_cmd_master_if.sv
// Requester command/response channel plus APB master bus.
interface apb_i2c_cmd_master_if;

  logic [1:0]       REQ_VALID;
  logic [1:0]       REQ_WRITE;
  logic [1:0][31:0] REQ_ADDR;
  logic [1:0][31:0] REQ_WDATA;
  logic [1:0]       REQ_READY;
  logic [1:0]       RSP_VALID;
  logic [31:0]      RSP_RDATA;
  logic             RSP_ERR;

  logic             PSELx;
  logic             PENABLE;
  logic             PWRITE;
  logic [31:0]      PADDR;
  logic [31:0]      PWDATA;
  logic [31:0]      PRDATA;
  logic             PREADY;
  logic             PSLVERR;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_rr_arb2.sv
// Two-requester round-robin arbiter; pointer names the preferred requester on contention.
module apb_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = pointer ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/apb_i2c_cmd_master.sv
// Arbitrates two command requesters onto one APB master port with a PREADY timeout.
module apb_i2c_cmd_master
  import apb_i2c_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_i2c_cmd_master_if.master bus
);

  localparam int              CW       = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_LIMIT - 1);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SETUP  = ST_SETUP;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] RESP   = ST_RESP;

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [1:0]    gnt;
  logic [1:0]    gnt_q, gnt_d;
  cmd_t          cmd_q, cmd_d, req_cmd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          sel;

  apb_rr_arb2 u_arb (
    .valid   (bus.REQ_VALID),
    .pointer (ptr_q),
    .grant   (gnt)
  );

  assign sel     = gnt[1];
  assign req_cmd = '{write: bus.REQ_WRITE[sel], addr: bus.REQ_ADDR[sel], wdata: bus.REQ_WDATA[sel]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (|gnt) begin
        gnt_d = gnt;
        ptr_d = gnt[0];
        // Illegal commands never touch the bus, so the APB address/data keep their last value.
        if (cmd_legal(req_cmd.write, req_cmd.addr)) begin
          cmd_d   = req_cmd;
          state_d = SETUP;
        end else begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rdata_d = cmd_q.write ? '0 : bus.PRDATA;
          err_d   = bus.PSLVERR;
          state_d = RESP;
        end else if (cnt_q >= CNT_LAST) begin
          cnt_d   = CNT_MAX;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.REQ_READY = (state_q == IDLE && PRESETn) ? gnt : 2'b00;
  assign bus.RSP_VALID = (state_q == RESP) ? gnt_q : 2'b00;
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;
  assign bus.PSELx     = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PWRITE    = cmd_q.write;
  assign bus.PADDR     = cmd_q.addr;
  assign bus.PWDATA    = cmd_q.wdata;

endmodule

// File: doc/apb_i2c_cmd_master.md
APB_I2C_CMD_MASTER -- requirements
Module: apb_i2c_cmd_master

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16: maximum ACCESS cycles without PREADY before a transfer is aborted.
REQ-002 SHALL have port PCLK  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port PRESETn  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port REQ_VALID  in  2  per-requester command valid; bit i belongs to requester i.
REQ-005 SHALL have port REQ_WRITE  in  2  per-requester direction; 1 = write.
REQ-006 SHALL have port REQ_ADDR  in  2x32  per-requester APB address.
REQ-007 SHALL have port REQ_WDATA  in  2x32  per-requester write data.
REQ-008 SHALL have port REQ_READY  out  2  one-cycle accept pulse per requester.
REQ-009 SHALL have port RSP_VALID  out  2  one-cycle completion pulse per requester.
REQ-010 SHALL have port RSP_RDATA  out  32  read data of the completed transfer.
REQ-011 SHALL have port RSP_ERR  out  1  error flag of the completed transfer.
REQ-012 SHALL have APB master ports PSELx, PENABLE and PWRITE  out  1; PADDR and PWDATA  out  32; PRDATA  in  32; PREADY and PSLVERR  in  1.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-014 IDLE, with any REQ_VALID high: SHALL grant one requester, pulse its REQ_READY in the same cycle, latch write/addr/wdata, and go to SETUP.
REQ-015 Arbitration SHALL be round-robin: a pointer (reset 0) names the preferred requester and moves to the other requester after each grant; a lone valid requester always wins.
REQ-016 SHALL treat only addresses 0 (TX), 4 (RX), 8 (CFG) and 12 (TMO) as legal; a write to 4 or a read from 0 SHALL also be illegal.
REQ-017 Illegal command: SHALL skip the APB bus and go IDLE->RESP with RSP_ERR=1 and RSP_RDATA=0.
REQ-018 SETUP: SHALL drive PSELx=1, PENABLE=0, and the latched PADDR/PWRITE/PWDATA for exactly one cycle, then go to ACCESS.
REQ-019 ACCESS: SHALL drive PSELx=1, PENABLE=1, with address, data and direction held stable.
REQ-020 ACCESS, on a PREADY=1 edge: SHALL capture PRDATA (reads; 0 for writes), capture PSLVERR into RSP_ERR, and go to RESP.
REQ-021 ACCESS: SHALL count cycles with PREADY=0; on reaching WAIT_LIMIT it SHALL deassert PSELx/PENABLE, set RSP_ERR=1, RSP_RDATA=0, and go to RESP.
REQ-022 RESP: SHALL pulse RSP_VALID for the granted requester only, for one cycle, then return to IDLE.
REQ-023 Minimum accept-to-RSP_VALID latency SHALL be 3 cycles: accept, SETUP, ACCESS with PREADY=1, then RSP_VALID.
REQ-024 The next command SHALL be accepted no earlier than the IDLE cycle that follows RESP.
REQ-025 Outside SETUP/ACCESS: SHALL drive PSELx=0 and PENABLE=0; PADDR/PWDATA SHALL keep their last value.
REQ-026 REQ_VALID changes after acceptance SHALL NOT affect the transfer in flight.
REQ-027 Simultaneous REQ_VALID=2'b11 SHALL produce exactly one REQ_READY bit per accept cycle, never both.
REQ-028 The wait counter SHALL be $clog2(WAIT_LIMIT+1) bits wide, SHALL clear on entry to ACCESS, and SHALL never wrap.

Reset
REQ-029 While PRESETn=0 at a clock edge, SHALL reset FSM to IDLE, pointer to 0, counter to 0, and all outputs to 0, including PADDR, PWDATA and RSP_RDATA.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no RSP_VALID generated.

Structure
REQ-031 SHALL place the FSM state enum and address constants ADDR_TX=0, ADDR_RX=4, ADDR_CFG=8, ADDR_TMO=12 in shared package apb_i2c_pkg.
REQ-032 SHALL place round-robin grant logic in sub-module apb_rr_arb2 (inputs: valid[1:0], pointer; output: one-hot grant[1:0]).

Verification
REQ-033 Scenario: req0 write addr 8 data 0x1234, PREADY=1 at first ACCESS -> PSELx high 2 cycles, PENABLE high 1 cycle, RSP_VALID[0] 3 cycles after REQ_READY[0], RSP_ERR=0.
REQ-034 Scenario: req1 read addr 4, PREADY delayed 3 cycles, PRDATA=0xA5A5A5A5 -> RSP_RDATA=0xA5A5A5A5, RSP_VALID[1] 6 cycles after accept.
REQ-035 Scenario: REQ_VALID=2'b11 held for 4 commands after reset -> grants in order 0,1,0,1.
REQ-036 Scenario: read addr 0 or write addr 16 -> no PSELx assertion, RSP_VALID with RSP_ERR=1 one cycle after accept.
REQ-037 Scenario: PREADY held 0 with WAIT_LIMIT=16 -> PSELx drops after 16 ACCESS cycles, RSP_ERR=1, RSP_RDATA=0.
REQ-038 Scenario: PRESETn=0 during ACCESS -> all outputs 0 next edge, no RSP_VALID; a following write addr 12 completes normally.
